mem_bus_sequencer: RTL

- Sequences the single shared memory bus between two requesters: the control unit's instruction-fetch path and the datapath's load/store path.
- Decodes each address to the ROM, RAM or peripheral region and drives the chip selects, write enable and size.
- Inserts per-region wait states, then returns data with a one-cycle ready pulse.
- Sits between the control unit/datapath and the memory/peripheral blocks.

---
 rtl/mem_bus_pkg.sv | 31 +++
 rtl/mem_bus_sequencer_if.sv | 41 ++++
 rtl/mem_region_decode.sv | 33 +++
 rtl/mem_bus_sequencer.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and defaults for the memory bus sequencer: FSM states, regions,
// grants, size codes and the alignment check used by the region decoder.
package mem_bus_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_PER} region_t;
    typedef enum logic {G_FETCH, G_DATA} grant_t;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] SZ_DOUBLE = 2'b11;

    localparam int WAIT_W = 4;

    localparam logic [31:0] DEF_ROM_LIMIT = 32'h0000_0400;
    localparam logic [31:0] DEF_RAM_LIMIT = 32'h0000_2000;
    localparam int          DEF_ROM_WAIT  = 1;
    localparam int          DEF_RAM_WAIT  = 2;
    localparam int          DEF_PER_WAIT  = 0;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lsb);
        case (size)
            SZ_HALF:   return lsb[0];
            SZ_WORD:   return |lsb[1:0];
            SZ_DOUBLE: return |lsb;
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_bus_sequencer_if.sv
// Requester and memory-side signals of the shared bus. The slave modport is the
// sequencer's view; master is the view of the surrounding requesters/memories.
interface mem_bus_sequencer_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic        dm_we;
    logic [1:0]  dm_size;
    logic [31:0] dm_addr;
    logic [63:0] dm_wdata;
    logic        dm_ready;
    logic [63:0] dm_rdata;
    logic        dm_err;

    logic [31:0] mem_address;
    logic [63:0] mem_wdata;
    logic [63:0] mem_data_in;
    logic        mem_write_en;
    logic        mem_read;
    logic [1:0]  mem_size;
    logic        rom_select;
    logic        ram_select;
    logic        per_select;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_size, dm_addr, dm_wdata, mem_data_in,
        output if_ready, if_rdata, dm_ready, dm_rdata, dm_err,
        output mem_address, mem_wdata, mem_write_en, mem_read, mem_size,
        output rom_select, ram_select, per_select
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_size, dm_addr, dm_wdata, mem_data_in,
        input  if_ready, if_rdata, dm_ready, dm_rdata, dm_err,
        input  mem_address, mem_wdata, mem_write_en, mem_read, mem_size,
        input  rom_select, ram_select, per_select
    );
endinterface

// File: rtl/mem_region_decode.sv
// Combinational address decode: region, wait count and access error
// (misalignment or store to ROM) for the request about to be granted.
module mem_region_decode
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] ROM_LIMIT = DEF_ROM_LIMIT,
    parameter logic [31:0] RAM_LIMIT = DEF_RAM_LIMIT,
    parameter int          ROM_WAIT  = DEF_ROM_WAIT,
    parameter int          RAM_WAIT  = DEF_RAM_WAIT,
    parameter int          PER_WAIT  = DEF_PER_WAIT
) (
    input  logic [31:0]       addr,
    input  logic [1:0]        size,
    input  logic              we,
    output region_t           region,
    output logic [WAIT_W-1:0] wait_cnt,
    output logic              err
);

    always_comb begin
        region   = REG_PER;
        wait_cnt = WAIT_W'(PER_WAIT);
        if (addr < ROM_LIMIT) begin
            region   = REG_ROM;
            wait_cnt = WAIT_W'(ROM_WAIT);
        end else if (addr < RAM_LIMIT) begin
            region   = REG_RAM;
            wait_cnt = WAIT_W'(RAM_WAIT);
        end
        err = misaligned(size, addr[2:0]) || (we && (region == REG_ROM));
    end

endmodule

// File: rtl/mem_bus_sequencer.sv
// Round-robin sequencer for the shared memory bus (fetch vs. load/store).
// Optional performance counters are built when MEM_BUS_PERF_COUNTERS_EN is defined.
module mem_bus_sequencer
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] ROM_LIMIT = DEF_ROM_LIMIT,
    parameter logic [31:0] RAM_LIMIT = DEF_RAM_LIMIT,
    parameter int          ROM_WAIT  = DEF_ROM_WAIT,
    parameter int          RAM_WAIT  = DEF_RAM_WAIT,
    parameter int          PER_WAIT  = DEF_PER_WAIT
) (
    input  logic                clock,
    input  logic                reset,
    mem_bus_sequencer_if.slave  bus,
    output logic                busy,
    output logic [31:0]         cnt_fetch,
    output logic [31:0]         cnt_data,
    output logic [31:0]         cnt_stall
);

    state_t            state;
    grant_t            grant;
    grant_t            last_grant;
    logic              lat_err;
    logic [WAIT_W-1:0] wcnt;
    logic [63:0]       rdata_q;

    logic              pick_fetch;
    logic [31:0]       sel_addr;
    logic [1:0]        sel_size;
    logic              sel_we;
    logic [63:0]       sel_wdata;
    region_t           dec_region;
    logic [WAIT_W-1:0] dec_wait;
    logic              dec_err;
    logic              dec_ok;

    // Fetch wins unless data is also requesting and fetch was served last.
    always_comb begin
        pick_fetch = bus.if_req && (!bus.dm_req || (last_grant == G_DATA));
        sel_addr   = pick_fetch ? bus.if_addr : bus.dm_addr;
        sel_size   = pick_fetch ? SZ_WORD : bus.dm_size;
        sel_we     = pick_fetch ? 1'b0 : bus.dm_we;
        sel_wdata  = pick_fetch ? 64'd0 : bus.dm_wdata;
        dec_ok     = !dec_err;
    end

    mem_region_decode #(
        .ROM_LIMIT (ROM_LIMIT),
        .RAM_LIMIT (RAM_LIMIT),
        .ROM_WAIT  (ROM_WAIT),
        .RAM_WAIT  (RAM_WAIT),
        .PER_WAIT  (PER_WAIT)
    ) u_decode (
        .addr     (sel_addr),
        .size     (sel_size),
        .we       (sel_we),
        .region   (dec_region),
        .wait_cnt (dec_wait),
        .err      (dec_err)
    );

    assign bus.if_rdata = rdata_q[31:0];
    assign bus.dm_rdata = rdata_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            grant            <= G_FETCH;
            last_grant       <= G_DATA;
            lat_err          <= 1'b0;
            wcnt             <= '0;
            rdata_q          <= '0;
            busy             <= 1'b0;
            bus.if_ready     <= 1'b0;
            bus.dm_ready     <= 1'b0;
            bus.dm_err       <= 1'b0;
            bus.mem_address  <= '0;
            bus.mem_wdata    <= '0;
            bus.mem_write_en <= 1'b0;
            bus.mem_read     <= 1'b0;
            bus.mem_size     <= '0;
            bus.rom_select   <= 1'b0;
            bus.ram_select   <= 1'b0;
            bus.per_select   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.if_req || bus.dm_req) begin
                        grant            <= pick_fetch ? G_FETCH : G_DATA;
                        lat_err          <= dec_err;
                        wcnt             <= dec_err ? '0 : dec_wait;
                        busy             <= 1'b1;
                        bus.mem_address  <= sel_addr;
                        bus.mem_size     <= sel_size;
                        bus.mem_wdata    <= sel_we ? sel_wdata : 64'd0;
                        bus.mem_read     <= dec_ok && !sel_we;
                        bus.mem_write_en <= dec_ok && sel_we;
                        bus.rom_select   <= dec_ok && (dec_region == REG_ROM);
                        bus.ram_select   <= dec_ok && (dec_region == REG_RAM);
                        bus.per_select   <= dec_ok && (dec_region == REG_PER);
                        state            <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wcnt != '0) begin
                        wcnt <= wcnt - WAIT_W'(1);
                    end else begin
                        rdata_q          <= bus.mem_data_in;
                        bus.mem_address  <= '0;
                        bus.mem_wdata    <= '0;
                        bus.mem_write_en <= 1'b0;
                        bus.mem_read     <= 1'b0;
                        bus.mem_size     <= '0;
                        bus.rom_select   <= 1'b0;
                        bus.ram_select   <= 1'b0;
                        bus.per_select   <= 1'b0;
                        bus.if_ready     <= (grant == G_FETCH);
                        bus.dm_ready     <= (grant == G_DATA);
                        bus.dm_err       <= (grant == G_DATA) && lat_err;
                        state            <= RESP;
                    end
                end
                RESP: begin
                    bus.if_ready <= 1'b0;
                    bus.dm_ready <= 1'b0;
                    bus.dm_err   <= 1'b0;
                    last_grant   <= grant;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_BUS_PERF_COUNTERS_EN
    logic other_waiting;

    assign other_waiting = (grant == G_FETCH) ? bus.dm_req : bus.if_req;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_fetch <= '0;
            cnt_data  <= '0;
            cnt_stall <= '0;
        end else begin
            if (state == RESP) begin
                if (grant == G_FETCH) cnt_fetch <= cnt_fetch + 32'd1;
                else                  cnt_data  <= cnt_data + 32'd1;
            end
            if ((state != IDLE) && other_waiting) cnt_stall <= cnt_stall + 32'd1;
        end
    end
`else
    assign cnt_fetch = '0;
    assign cnt_data  = '0;
    assign cnt_stall = '0;
`endif

endmodule
